rgb2ycbcr_job_ctrl: RTL and testbench
=====================================

Name: rgb2ycbcr_job_ctrl

Overview:
- Job sequencer for the RGB->YCbCr streaming datapath.
- Accepts a start command with a beat count, then opens the upstream->datapath and datapath->downstream handshakes for exactly that many beats. Pixel data bypasses this block; only valid/ready lines are controlled.
- Closes both gates after the last beat and pulses done.
- Tracks accepted input beats and delivered output beats; works with the combinational converter or with a pipelined datapath of any latency.

Parameters:
- LEN_WIDTH, 16, width of the job length and of both beat counters.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  reset, synchronous, active-low.
- start_i  in  1  start a job; sampled only in IDLE.
- len_i  in  LEN_WIDTH  job length in stream beats; latched when start_i is accepted.
- clear_i  in  1  synchronous abort.
- busy_o  out  1  high in RUN and DRAIN.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  sticky protocol error.
- in_cnt_o  out  LEN_WIDTH  input beats accepted in the current or last job.
- out_cnt_o  out  LEN_WIDTH  output beats delivered in the current or last job.
- up_valid_i  in  1  upstream RGB stream valid.
- up_ready_o  out  1  upstream RGB stream ready.
- dp_valid_o  out  1  datapath input valid.
- dp_ready_i  in  1  datapath input ready.
- dp_out_valid_i  in  1  datapath output valid.
- dp_out_ready_o  out  1  datapath output ready.
- down_valid_o  out  1  downstream YCbCr stream valid.
- down_ready_i  in  1  downstream YCbCr stream ready.

Behaviour:
- Reset: clock is clk_i; reset is synchronous and active-low on rst_ni. On reset: state=IDLE, len register=0, in_cnt=0, out_cnt=0, err_o=0, done_o=0, busy_o=0. All gated valid/ready outputs are 0.
- States:
  - IDLE: both gates closed. start_i=1 with len_i!=0: latch len, zero both counters, clear err, go to RUN. start_i=1 with len_i==0: zero counters, go to DONE (no beats).
  - RUN: input gate open while in_cnt<len; output gate open while out_cnt<len. in_cnt reaching len (with out_cnt<len) -> DRAIN. out_cnt reaching len -> DONE.
  - DRAIN: input gate closed, output gate open while out_cnt<len; out_cnt reaching len -> DONE.
  - DONE: done_o=1 for exactly this cycle, gates closed, next state IDLE.
- Input gate (open condition g_in = RUN and in_cnt<len):
  - dp_valid_o = up_valid_i & g_in.
  - up_ready_o = dp_ready_i & g_in.
  - in_cnt increments on up_valid_i & up_ready_o.
- Output gate (open condition g_out = (RUN or DRAIN) and out_cnt<len):
  - down_valid_o = dp_out_valid_i & g_out.
  - dp_out_ready_o = down_ready_i & g_out.
  - out_cnt increments on dp_out_valid_i & dp_out_ready_o.
- Gating: paths are combinational with no added latency; data is never registered here.
- Simultaneous events: input and output handshakes in the same cycle both count. When the last input and last output beat land in the same cycle, go RUN->DONE directly; DRAIN is skipped.
- Counters: unsigned, saturate at len by construction and never wrap. Both hold their final values after DONE until the next accepted start.
- Maximum job length is 2^LEN_WIDTH-1 beats.
- err_o: set when dp_out_valid_i=1 in IDLE or DONE, or when an output handshake would make out_cnt exceed in_cnt. err_o is cleared only by reset, clear_i or an accepted start. It does not alter sequencing.
- start_i while busy or in DONE is ignored; len_i is not resampled.
- clear_i priority: clear_i > start_i > normal progress. On clear_i: state=IDLE, counters=0, err=0, no done pulse, gates closed from the next cycle. In-flight datapath beats are dropped by the datapath owner.
- Reset asserted mid-job behaves as clear_i; the entire state returns to reset values on the next edge.

Test Plan:
- Basic job: len=4, up_valid and down_ready held high, dp_ready=1, combinational loopback dp_out_valid=dp_valid.
  - Expect 4 beats on consecutive cycles.
  - busy_o high 4 cycles, done_o pulse on cycle 5.
  - in_cnt=out_cnt=4.
  - up_ready_o=0 after the 4th beat.
- Downstream backpressure: len=3, down_ready toggling 1,0,1,0,1.
  - Expect exactly 3 output beats, none while down_ready=0.
  - With loopback, up_ready_o follows down_ready; done_o one cycle after the 3rd beat.
- Pipelined datapath: 2-cycle latency model, len=5.
  - Expect RUN->DRAIN after the 5th input beat, two cycles in DRAIN, then DONE.
  - out_cnt=5; err_o stays 0.
- Zero length: start with len_i=0.
  - Expect no gate opening, busy_o never high, done_o pulse the cycle after start.
- Abort: len=10, assert clear_i after 3 beats.
  - Next cycle: IDLE, counters 0, gates closed, no done_o.
  - A start_i asserted in the same cycle as clear_i is ignored.
- Protocol error: drive dp_out_valid_i=1 in IDLE.
  - Expect err_o=1 sticky and down_valid_o=0.
  - A subsequent start with len=2 clears err_o and the job completes normally.

Source files
------------

// File: rtl/rgb2ycbcr_job_ctrl.sv
// Job sequencer for the RGB->YCbCr stream: opens the input and output handshakes for exactly
// len beats, then closes both gates and pulses done. Only valid/ready lines pass through here.
module rgb2ycbcr_job_ctrl #(
  parameter int unsigned LEN_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  input  logic                 clear_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [LEN_WIDTH-1:0] in_cnt_o,
  output logic [LEN_WIDTH-1:0] out_cnt_o,
  input  logic                 up_valid_i,
  output logic                 up_ready_o,
  output logic                 dp_valid_o,
  input  logic                 dp_ready_i,
  input  logic                 dp_out_valid_i,
  output logic                 dp_out_ready_o,
  output logic                 down_valid_o,
  input  logic                 down_ready_i
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e               state_q;
  logic [LEN_WIDTH-1:0] len_q, in_cnt_q, out_cnt_q;
  logic [LEN_WIDTH-1:0] in_cnt_d, out_cnt_d;
  logic                 err_q;
  logic                 g_in, g_out, in_hs, out_hs, err_set;

  always_comb begin
    g_in  = (state_q == StRun) && (in_cnt_q < len_q);
    g_out = ((state_q == StRun) || (state_q == StDrain)) && (out_cnt_q < len_q);

    dp_valid_o     = up_valid_i & g_in;
    up_ready_o     = dp_ready_i & g_in;
    down_valid_o   = dp_out_valid_i & g_out;
    dp_out_ready_o = down_ready_i & g_out;

    in_hs  = up_valid_i & up_ready_o;
    out_hs = dp_out_valid_i & dp_out_ready_o;

    in_cnt_d  = in_cnt_q + {{(LEN_WIDTH-1){1'b0}}, in_hs};
    out_cnt_d = out_cnt_q + {{(LEN_WIDTH-1){1'b0}}, out_hs};

    // Output beats arriving while no job is open, or overtaking accepted input beats.
    err_set = (((state_q == StIdle) || (state_q == StDone)) && dp_out_valid_i) ||
              (out_hs && (out_cnt_q >= in_cnt_d));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      len_q     <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      err_q     <= 1'b0;
    end else if (clear_i) begin
      state_q   <= StIdle;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= err_q | err_set;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            err_q     <= 1'b0;
            if (len_i != '0) begin
              len_q   <= len_i;
              state_q <= StRun;
            end else begin
              state_q <= StDone;
            end
          end
        end
        StRun, StDrain: begin
          in_cnt_q  <= in_cnt_d;
          out_cnt_q <= out_cnt_d;
          // Last output beat wins, so a simultaneous last in/out beat skips DRAIN.
          if (out_cnt_d == len_q) begin
            state_q <= StDone;
          end else if ((state_q == StRun) && (in_cnt_d == len_q)) begin
            state_q <= StDrain;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o    = (state_q == StRun) || (state_q == StDrain);
  assign done_o    = (state_q == StDone);
  assign err_o     = err_q;
  assign in_cnt_o  = in_cnt_q;
  assign out_cnt_o = out_cnt_q;

endmodule

// File: tb/tb_rgb2ycbcr_job_ctrl.sv
// Bench for rgb2ycbcr_job_ctrl: directed jobs plus random traffic, all checked against a
// job-level model of counters, phase and error flag.
module tb_rgb2ycbcr_job_ctrl;

  localparam int unsigned LW = 16;
  localparam int ModeRaw  = 0;
  localparam int ModeComb = 1;
  localparam int ModePipe = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, clear = 1'b0;
  logic [LW-1:0] len = '0;
  logic          busy, done, err;
  logic [LW-1:0] in_cnt, out_cnt;
  logic          up_valid = 1'b0, up_ready, dp_valid, dp_ready, dp_out_valid, dp_out_ready;
  logic          down_valid, down_ready = 1'b0;
  logic          dp_ready_r = 1'b0, dov_r = 1'b0;
  logic          p1 = 1'b0, p2 = 1'b0;
  int            mode = ModeRaw;

  int n_checks = 0;
  int n_fail   = 0;
  int beats    = 0;

  // Job-level model: phase 0 idle, 1 run, 2 drain, 3 done.
  int m_phase = 0, m_len = 0, m_in = 0, m_out = 0;
  bit m_err = 0;

  always #5 clk = ~clk;

  // Environment: combinational converter, 2-cycle pipeline, or free-running raw lines.
  assign dp_ready     = (mode == ModeComb) ? dp_out_ready : dp_ready_r;
  assign dp_out_valid = (mode == ModeComb) ? dp_valid : (mode == ModePipe) ? p2 : dov_r;

  always @(posedge clk) begin
    p1 <= (mode == ModePipe) && dp_valid && dp_ready;
    p2 <= p1;
  end

  rgb2ycbcr_job_ctrl #(.LEN_WIDTH(LW)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .len_i          (len),
    .clear_i        (clear),
    .busy_o         (busy),
    .done_o         (done),
    .err_o          (err),
    .in_cnt_o       (in_cnt),
    .out_cnt_o      (out_cnt),
    .up_valid_i     (up_valid),
    .up_ready_o     (up_ready),
    .dp_valid_o     (dp_valid),
    .dp_ready_i     (dp_ready),
    .dp_out_valid_i (dp_out_valid),
    .dp_out_ready_o (dp_out_ready),
    .down_valid_o   (down_valid),
    .down_ready_i   (down_ready)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One cycle: drive at negedge, check outputs 1ns later, advance model, wait next negedge.
  task automatic step(input bit rs, input bit clr, input bit st, input int ln, input bit uv,
                      input bit dr, input bit dov, input bit dnr);
    bit g_in, g_out, e_dpv, e_upr, e_dnv, e_dor, dr_eff, dov_eff, in_hs, out_hs;
    rst_n = rs; clear = clr; start = st; len = LW'(ln);
    up_valid = uv; dp_ready_r = dr; dov_r = dov; down_ready = dnr;
    #1;
    g_in  = (m_phase == 1) && (m_in < m_len);
    g_out = (m_phase == 1 || m_phase == 2) && (m_out < m_len);
    e_dpv = uv && g_in;
    e_dor = dnr && g_out;
    dr_eff  = (mode == ModeComb) ? e_dor : dr;
    dov_eff = (mode == ModeComb) ? e_dpv : (mode == ModePipe) ? p2 : dov;
    e_upr = dr_eff && g_in;
    e_dnv = dov_eff && g_out;
    check_eq("busy", busy, (m_phase == 1 || m_phase == 2));
    check_eq("done", done, m_phase == 3);
    check_eq("err", err, m_err);
    check_eq("in_cnt", in_cnt, m_in);
    check_eq("out_cnt", out_cnt, m_out);
    check_eq("dp_valid", dp_valid, e_dpv);
    check_eq("up_ready", up_ready, e_upr);
    check_eq("down_valid", down_valid, e_dnv);
    check_eq("dp_out_ready", dp_out_ready, e_dor);
    if (down_valid && dnr) beats++;
    in_hs  = uv && e_upr;
    out_hs = dov_eff && e_dor;
    if (!rs) begin
      m_phase = 0; m_len = 0; m_in = 0; m_out = 0; m_err = 0;
    end else if (clr) begin
      m_phase = 0; m_in = 0; m_out = 0; m_err = 0;
    end else if (m_phase == 0) begin
      if (st) begin
        m_in = 0; m_out = 0; m_err = 0;
        if (ln != 0) begin m_len = ln; m_phase = 1; end
        else m_phase = 3;
      end else if (dov_eff) m_err = 1;
    end else if (m_phase == 3) begin
      if (dov_eff) m_err = 1;
      m_phase = 0;
    end else begin
      if (out_hs && (m_out + 1 > m_in + int'(in_hs))) m_err = 1;
      m_in  += int'(in_hs);
      m_out += int'(out_hs);
      if (m_out == m_len) m_phase = 3;
      else if (m_phase == 1 && m_in == m_len) m_phase = 2;
    end
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    @(negedge clk);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 7, 1, 1, 1, 1);
    idle_cycles(1);

    // Basic job through the combinational converter.
    mode = ModeComb; beats = 0;
    step(1, 0, 1, 4, 1, 1, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 1, 1, 0, 1);
    check_eq("basic_beats", beats, 4);
    check_eq("basic_in_cnt", in_cnt, 4);
    check_eq("basic_out_cnt", out_cnt, 4);

    // Downstream backpressure.
    beats = 0;
    step(1, 0, 1, 3, 1, 1, 0, 1);
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 1, 1, 0, (i % 2 == 0));
    check_eq("bp_beats", beats, 3);

    // Two-cycle pipelined datapath.
    mode = ModePipe;
    step(1, 0, 1, 5, 1, 1, 0, 1);
    for (int i = 0; i < 9; i++) step(1, 0, 0, 0, 1, 1, 0, 1);
    check_eq("pipe_out_cnt", out_cnt, 5);
    check_eq("pipe_err", err, 0);

    // Zero length, then abort with a coincident start.
    mode = ModeComb;
    step(1, 0, 1, 0, 1, 1, 0, 1);
    idle_cycles(2);
    step(1, 0, 1, 10, 1, 1, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 1, 0, 1);
    step(1, 1, 1, 6, 1, 1, 0, 1);
    step(1, 0, 0, 0, 1, 1, 0, 1);
    check_eq("abort_busy", busy, 0);

    // Protocol error in IDLE, then a normal job clears it.
    mode = ModeRaw;
    step(1, 0, 0, 0, 0, 0, 1, 1);
    step(1, 0, 0, 0, 0, 0, 1, 1);
    check_eq("perr_sticky", err, 1);
    mode = ModeComb;
    step(1, 0, 1, 2, 1, 1, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 1, 1, 0, 1);
    check_eq("perr_cleared", err, 0);

    // Random traffic, alternating environments per block.
    for (int blk = 0; blk < 12; blk++) begin
      mode = (blk % 2 == 0) ? ModeRaw : ModeComb;
      for (int i = 0; i < 250; i++)
        step(($urandom % 150) != 0, ($urandom % 40) == 0, ($urandom % 4) == 0,
             int'($urandom % 7), $urandom % 2, $urandom % 2, ($urandom % 3) == 0, $urandom % 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
